uart_rx_core: RTL and testbench

//  Receive side of the UART link; counterpart to the UART TX FSM/serializer path.

---
 rtl/uart_rx_core.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// UART receive core: synchronizes and oversamples the serial line, recovers an LSB-first
// frame with optional parity, and reports each frame as good, parity error or stop error.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [PRESCALE_W-1:0] ONE_P = {{(PRESCALE_W-1){1'b0}}, 1'b1};
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    rx_meta_r;
    logic                    rx_sync_r;
    logic [PRESCALE_W-1:0]   edge_cnt_r;
    logic [BIT_CNT_W-1:0]    bit_cnt_r;
    logic [DATA_WIDTH-1:0]   shift_r;
    logic [2:0]              samp_r;
    logic                    par_bad_r;
    logic [PRESCALE_W-1:0]   half_s;
    logic                    bit_end_s;
    logic                    maj_s;
    logic                    last_data_s;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    function automatic logic exp_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    assign half_s      = prescale >> 1;
    assign bit_end_s   = (edge_cnt_r == (prescale - ONE_P));
    assign maj_s       = maj3(samp_r);
    assign last_data_s = (bit_cnt_r == LAST_BIT);

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!rx_sync_r) state_nxt_s = ST_START;
                else            state_nxt_s = ST_IDLE;
            end
            ST_START: begin
                if (bit_end_s) state_nxt_s = maj_s ? ST_IDLE : ST_DATA;
                else           state_nxt_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && last_data_s) state_nxt_s = par_en ? ST_PARITY : ST_STOP;
                else                          state_nxt_s = ST_DATA;
            end
            ST_PARITY: begin
                if (bit_end_s) state_nxt_s = ST_STOP;
                else           state_nxt_s = ST_PARITY;
            end
            ST_STOP: begin
                if (bit_end_s) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_STOP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Line synchronizer, state register and registered busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            state_r   <= ST_IDLE;
            busy      <= 1'b0;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
            state_r   <= state_nxt_s;
            busy      <= (state_nxt_s != ST_IDLE);
        end
    end

    // Bit timing: the idle cycle that sees the line low is edge 0 of the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt_r <= '0;
            samp_r     <= 3'b111;
        end else if (state_r == ST_IDLE) begin
            edge_cnt_r <= rx_sync_r ? '0 : ONE_P;
            samp_r     <= 3'b111;
        end else begin
            edge_cnt_r <= bit_end_s ? '0 : (edge_cnt_r + ONE_P);
            if (edge_cnt_r == (half_s - ONE_P)) samp_r[0] <= rx_sync_r;
            if (edge_cnt_r == half_s)           samp_r[1] <= rx_sync_r;
            if (edge_cnt_r == (half_s + ONE_P)) samp_r[2] <= rx_sync_r;
        end
    end

    // Data capture, parity tracking and end-of-frame result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r  <= '0;
            shift_r    <= '0;
            par_bad_r  <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= '0;
                    par_bad_r <= 1'b0;
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        shift_r   <= {maj_s, shift_r[DATA_WIDTH-1:1]};
                        bit_cnt_r <= bit_cnt_r + {{(BIT_CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_PARITY: begin
                    if (bit_end_s) par_bad_r <= (maj_s != exp_parity(shift_r, par_typ));
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        stp_err    <= ~maj_s;
                        par_err    <= maj_s & par_bad_r;
                        data_valid <= maj_s & ~par_bad_r;
                        if (maj_s && !par_bad_r) data_out <= shift_r;
                    end
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Randomized and directed bench for uart_rx_core; a frame-level model predicts one result
// per frame, which is compared with the pulses observed on the outputs.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] data_out;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    int         obs_kind[$];
    logic [7:0] obs_data[$];
    int         exp_kind[$];
    logic [7:0] exp_data[$];
    logic [7:0] last_good = 8'h00;

    uart_rx_core #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk(clk), .rst(rst), .rx_in(rx_in), .prescale(prescale),
        .par_en(par_en), .par_typ(par_typ), .data_out(data_out),
        .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 1 good, 2 parity error, 3 stop error, 4 more than one pulse at once
    always @(negedge clk) begin
        if (data_valid || par_err || stp_err) begin
            if ((32'(data_valid) + 32'(par_err) + 32'(stp_err)) > 1) obs_kind.push_back(4);
            else if (data_valid) obs_kind.push_back(1);
            else if (par_err)    obs_kind.push_back(2);
            else                 obs_kind.push_back(3);
            obs_data.push_back(data_out);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // cb: frame bit index to corrupt (-1 none, -2 random), co: 0..2 selects which sample
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit,
                              input int cb, input int co, input int stop_after);
        logic bits[$];
        int   p = int'(prescale);
        int   cyc = 0;
        int   ci;
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (par_en) bits.push_back(pbit);
        bits.push_back(sbit);
        if (stop_after < 0) begin
            if (!sbit) exp_kind.push_back(3);
            else if (par_en && (pbit != ((^d) ^ par_typ))) exp_kind.push_back(2);
            else begin
                exp_kind.push_back(1);
                last_good = d;
            end
            exp_data.push_back(d);
        end
        for (int k = 0; k < bits.size(); k++) begin
            ci = -1;
            if (cb == k) ci = p / 2 - 1 + co;
            else if (cb == -2 && $urandom_range(0, 3) == 0) ci = p / 2 - 1 + int'($urandom_range(0, 2));
            for (int i = 0; i < p; i++) begin
                if (stop_after >= 0 && cyc == stop_after) return;
                rx_in = (i == ci) ? ~bits[k] : bits[k];
                @(negedge clk);
                cyc++;
            end
        end
        rx_in = 1'b1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_batch(input string tag);
        int n;
        idle(2 * int'(prescale) + 8);
        chk({tag, "_count"}, obs_kind.size(), exp_kind.size());
        n = (obs_kind.size() < exp_kind.size()) ? obs_kind.size() : exp_kind.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_kind"}, obs_kind[i], exp_kind[i]);
            if (exp_kind[i] == 1) chk({tag, "_data"}, obs_data[i], exp_data[i]);
        end
        chk({tag, "_data_out"}, data_out, last_good);
        chk({tag, "_busy"}, busy, 0);
        obs_kind.delete(); obs_data.delete(); exp_kind.delete(); exp_data.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       pb;
        int         nf;
        rx_in = 1'b1; rst = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {data_out, data_valid, par_err, stp_err, busy}, 0);
        rst = 1'b0;
        idle(4);

        // plain frame
        send_frame(8'h3C, 1'b0, 1'b1, -1, 0, -1);
        check_batch("t1");

        // even parity, good then bad parity bit
        par_en = 1'b1; par_typ = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b1, -1, 0, -1);
        check_batch("t2_good");
        send_frame(8'hA5, 1'b1, 1'b1, -1, 0, -1);
        check_batch("t2_bad");

        // short start glitch
        prescale = 6'd16; par_en = 1'b0;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        chk("t3_busy", busy, 1);
        check_batch("t3");

        // stop error then recovery
        prescale = 6'd8;
        send_frame(8'h55, 1'b0, 1'b0, -1, 0, -1);
        check_batch("t4_stp");
        send_frame(8'h0F, 1'b0, 1'b1, -1, 0, -1);
        check_batch("t4_ok");

        // one sample of bit 0 forced low, each sample position in turn
        for (int s = 0; s < 3; s++) begin
            send_frame(8'h81, 1'b0, 1'b1, 1, s, -1);
            check_batch("t5");
        end

        // reset during data bit 3
        send_frame(8'hE7, 1'b0, 1'b1, -1, 0, 4 * 8 + 4);
        chk("t6_busy_pre", busy, 1);
        rx_in = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_reset_outs", {data_out, data_valid, par_err, stp_err, busy}, 0);
        last_good = 8'h00;
        check_batch("t6_rst");

        // back-to-back frames
        send_frame(8'h12, 1'b0, 1'b1, -1, 0, -1);
        send_frame(8'h34, 1'b0, 1'b1, -1, 0, -1);
        check_batch("t6_b2b");

        // randomized batches
        for (int b = 0; b < 12; b++) begin
            prescale = 6'(2 * $urandom_range(4, 31));
            par_en   = 1'($urandom_range(0, 1));
            par_typ  = 1'($urandom_range(0, 1));
            nf = int'($urandom_range(1, 3));
            for (int f = 0; f < nf; f++) begin
                d  = 8'($urandom);
                pb = (^d) ^ par_typ;
                if ($urandom_range(0, 4) == 0) pb = ~pb;
                send_frame(d, pb, ($urandom_range(0, 5) != 0), -2, 0, -1);
                idle(int'($urandom_range(0, 2)));
            end
            check_batch("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
